// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared types and geometry for the direct-mapped icache.
//  Revision    : 1.0  initial release
// ============================================================================
package icache_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    // Fetch address split for the default 16-set geometry.
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icstate_t;

    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_if
//  Description : Fetch-side and fill-side signals of one core's icache.
//  Revision    : 1.0  initial release
// ============================================================================
interface icache_if;
    import icache_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport icache (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    // Datapath fetch stage plus memory controller instruction port.
    modport env (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped read-only instruction cache, one-word frames,
//                single-word fill through the controller instruction port.
//  Revision    : 1.0  initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int CPUID = 0
) (
    input  wire logic CLK,
    input  wire logic nRST,
    icache_if.icache  cif
);

    localparam int c_idx_w = $clog2(SETS);
    localparam int c_tag_w = 30 - c_idx_w;

    icstate_t             r_state;
    logic [SETS-1:0]      r_valid;
    logic [c_tag_w-1:0]   r_tag  [SETS];
    word_t                r_data [SETS];
    logic [29:0]          r_missaddr;
    logic                 r_iren;

    logic [c_idx_w-1:0]   w_idx;
    logic [c_tag_w-1:0]   w_tag;
    logic [c_idx_w-1:0]   w_fidx;
    logic [c_tag_w-1:0]   w_ftag;
    logic                 w_hit;
    logic                 w_fill_done;
    wire                  w_unused;

    assign w_idx  = cif.imemaddr[2+c_idx_w-1:2];
    assign w_tag  = cif.imemaddr[31:2+c_idx_w];
    assign w_fidx = r_missaddr[c_idx_w-1:0];
    assign w_ftag = r_missaddr[29:c_idx_w];

    // Lookups are only honoured in IDLE; a fill in flight masks all hits.
    assign w_hit       = (r_state == IDLE) & cif.imemREN & r_valid[w_idx]
                       & (r_tag[w_idx] == w_tag);
    assign w_fill_done = (r_state == FILL) & ~cif.iwait;

    assign cif.ihit     = w_hit;
    assign cif.imemload = w_hit ? r_data[w_idx] : '0;
    assign cif.iREN     = r_iren;
    assign cif.iaddr    = {r_missaddr, 2'b00};

    assign w_unused = &{1'b0, cif.imemaddr[1:0], CPUID[0]};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_valid    <= '0;
            r_missaddr <= '0;
            r_iren     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cif.imemREN && !w_hit) begin
                        r_missaddr <= cif.imemaddr[31:2];
                        r_iren     <= 1'b1;
                        r_state    <= FILL;
                    end
                end
                FILL: begin
                    if (!cif.iwait) begin
                        r_valid[w_fidx] <= 1'b1;
                        r_iren          <= 1'b0;
                        r_state         <= IDLE;
                    end
                end
                default: begin
                    r_iren  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Tag/data need no reset: valid bits alone qualify them, and reset forces
    // IDLE so an interrupted fill can never land here.
    always_ff @(posedge CLK) begin
        if (w_fill_done) begin
            r_tag[w_fidx]  <= w_ftag;
            r_data[w_fidx] <= cif.iload;
        end
    end

endmodule
`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipeline's fetch stage and the coherence/arbitration controller. It serves instruction fetches from a local tag/data array. On a miss it issues a single-word fill through the controller's instruction port (iREN/iaddr/iwait/iload) and holds that request until the controller drops iwait. One instance per core; the controller's instruction port index equals the core number.

## Interface
Parameters:
- SETS, 16, number of one-word frames; power of two, at least 2.
- CPUID, 0, core index; informational, selects no logic.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- imemREN  in  1  fetch request from the datapath.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  fetch satisfied this cycle; imemload valid.
- imemload  out  32  fetched instruction word; 0 when ihit=0.
- iREN  out  1  fill request to the memory controller.
- iaddr  out  32  fill word address, bits [1:0] = 0.
- iwait  in  1  controller stall; 0 means iload is valid this cycle.
- iload  in  32  fill data from the controller.

## Operation
- Address split: tag = imemaddr[31:2+IDX_W], idx = imemaddr[2+IDX_W-1:2], byte offset = imemaddr[1:0]. IDX_W = $clog2(SETS).
- Each frame holds: valid (1 bit), tag (30−IDX_W bits), data (32 bits).
- State machine states are IDLE and FILL.
- IDLE:
  - hit = imemREN & valid[idx] & (tag[idx] == tag).
  - On hit: ihit=1 and imemload=data[idx], both combinational in the same cycle.
  - On imemREN & !hit: latch missaddr = {imemaddr[31:2], 2'b00} and go to FILL. ihit=0.
  - iREN=0 throughout IDLE.
- FILL:
  - iREN=1 and iaddr=missaddr; ihit=0.
  - On the edge where iwait=0: write the frame at missaddr's idx with valid=1, its tag, and data=iload, then go to IDLE.
  - While iwait=1, stay in FILL.
- A fill always completes once started, even if imemREN drops or imemaddr changes during FILL. The new address is evaluated in IDLE after the fill.
- The cache never writes to memory and has no dirty state. Self-modifying code is not supported.
- Reset clears every valid bit, sets state to IDLE, and clears missaddr to 0. Tag and data arrays need no reset.

## Timing
- Reset values: ihit=0, imemload=0, iREN=0, iaddr=0.
- Hit latency is 0 cycles (combinational, same cycle).
- Miss sequence:
  - cycle 0: miss detected in IDLE.
  - cycles 1..N: FILL with iREN=1, ending on the first cycle where iwait=0. Frame is written at the end of that cycle.
  - cycle N+1: IDLE, ihit=1 for the same address.
  - Minimum miss penalty is 2 cycles (iwait=0 in the first FILL cycle).
- iREN is held high continuously from FILL entry to fill completion, and iaddr is stable throughout.
- iREN drops in the cycle after iwait=0, as the FSM returns to IDLE.
- Conflict miss (same idx, different tag) overwrites the frame. No replacement choice exists.
- Reset asserted mid-FILL: iREN=0 immediately (asynchronous) and the partially fetched word is discarded. After reset release the first fetch misses.
- imemREN=0 in IDLE: no state change, ihit=0.

## Structure
- cpu_types_pkg provides word_t (32-bit).
- New package items:
  - ICACHE_SETS = 16.
  - icachef_t: packed struct {tag, idx, bytoff} for the 16-set geometry.
  - icache_frame_t: packed struct {valid, tag, data}.
  - icstate_t: enum logic {IDLE, FILL}.
- No sub-module. The frame array is a flip-flop array inside icache. Add the port list as a modport "icache" on the existing caches interface so that top-level wiring matches the controller's iREN/iaddr/iwait/iload arrays.

## Test plan
- Reset then fetch 0x00000040 with iwait=1 for 3 cycles, then iwait=0 and iload=0x2001000A → iREN=1 and iaddr=0x40 for 4 cycles; next cycle ihit=1 and imemload=0x2001000A.
- Refetch 0x00000042 after the fill above → ihit=1 in the same cycle, imemload=0x2001000A, iREN stays 0.
- Conflict: fill 0x40, then fetch 0x80 (same idx 0, new tag) with iload=0x8C220004 → miss and refill; a following fetch of 0x40 misses again.
- Miss on 0x44, then change imemaddr to 0x100 and drop imemREN during FILL → iaddr stays 0x44 until iwait=0; frame idx 1 then holds 0x44's data; 0x100 misses afterward.
- Assert nRST low mid-FILL → iREN=0 and ihit=0 asynchronously; after release, fetch 0x40 misses even though it was filled before reset.
- Back-to-back fetches 0x0, 0x4, … 0x3C with one-cycle iwait → 16 fills. A second pass over the same addresses hits every cycle with zero iREN activity.
